// File: rtl/carrd_vrf_if.sv
// carrd_vrf_if: writeback/issue/operand-fetch bundle for the Carrd vector register file
interface carrd_vrf_if #(
  parameter int NUM_REGS = 32,
  parameter int LANE_W   = 128
);
  localparam int AW = $clog2(NUM_REGS);
  logic                  v_reg_wr_en;
  logic                  el_wr_en;
  logic [AW-1:0]         reg_wr_addr;
  logic [LANE_W-1:0]     reg_wr_data;
  logic [LANE_W-1:0]     reg_wr_data_2;
  logic [LANE_W-1:0]     reg_wr_data_3;
  logic [LANE_W-1:0]     reg_wr_data_4;
  logic                  rd_en;
  logic [AW-1:0]         rd_addr_1;
  logic [AW-1:0]         rd_addr_2;
  logic [4*LANE_W-1:0]   rd_data_1;
  logic [4*LANE_W-1:0]   rd_data_2;
  logic                  rd_valid;
  logic                  sb_set;
  logic [AW-1:0]         sb_addr;
  logic                  busy_1;
  logic                  busy_2;
  modport master (
    output v_reg_wr_en, el_wr_en, reg_wr_addr, reg_wr_data, reg_wr_data_2, reg_wr_data_3,
           reg_wr_data_4, rd_en, rd_addr_1, rd_addr_2, sb_set, sb_addr,
    input  rd_data_1, rd_data_2, rd_valid, busy_1, busy_2
  );
  modport slave (
    input  v_reg_wr_en, el_wr_en, reg_wr_addr, reg_wr_data, reg_wr_data_2, reg_wr_data_3,
           reg_wr_data_4, rd_en, rd_addr_1, rd_addr_2, sb_set, sb_addr,
    output rd_data_1, rd_data_2, rd_valid, busy_1, busy_2
  );
endinterface

// File: rtl/carrd_vrf.sv
// carrd_vrf: 32x512b vector register file, two registered read ports, busy scoreboard.
// Define CARRD_VRF_BYPASS_EN to return post-write data on same-cycle read/write collisions.
module carrd_vrf #(
  parameter int NUM_REGS = 32,
  parameter int LANE_W   = 128,
  parameter int ELEM_W   = 32
) (
  input logic       clk,
  input logic       nrst,
  carrd_vrf_if.slave bus
);
  localparam int REG_W = 4 * LANE_W;
  logic [REG_W-1:0]    regs [NUM_REGS];
  logic [NUM_REGS-1:0] sb;
  logic                wr_act;
  logic [REG_W-1:0]    wr_val;
  logic [REG_W-1:0]    rv_1;
  logic [REG_W-1:0]    rv_2;
  assign wr_act = bus.v_reg_wr_en | bus.el_wr_en;
  // full write takes priority; element write keeps the upper bits of the old value
  assign wr_val = bus.v_reg_wr_en
    ? {bus.reg_wr_data_4, bus.reg_wr_data_3, bus.reg_wr_data_2, bus.reg_wr_data}
    : {regs[bus.reg_wr_addr][REG_W-1:ELEM_W], bus.reg_wr_data[ELEM_W-1:0]};
`ifdef CARRD_VRF_BYPASS_EN
  assign rv_1 = (wr_act && bus.reg_wr_addr == bus.rd_addr_1) ? wr_val : regs[bus.rd_addr_1];
  assign rv_2 = (wr_act && bus.reg_wr_addr == bus.rd_addr_2) ? wr_val : regs[bus.rd_addr_2];
`else
  assign rv_1 = regs[bus.rd_addr_1];
  assign rv_2 = regs[bus.rd_addr_2];
`endif
  assign bus.busy_1 = sb[bus.rd_addr_1];
  assign bus.busy_2 = sb[bus.rd_addr_2];
  always_ff @(posedge clk) begin
    if (!nrst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      sb            <= '0;
      bus.rd_data_1 <= '0;
      bus.rd_data_2 <= '0;
      bus.rd_valid  <= 1'b0;
    end else begin
      if (wr_act) regs[bus.reg_wr_addr] <= wr_val;
      if (wr_act) sb[bus.reg_wr_addr] <= 1'b0;
      // a set issued on the same edge as the clearing write reflects a newer producer
      if (bus.sb_set) sb[bus.sb_addr] <= 1'b1;
      bus.rd_valid <= bus.rd_en;
      if (bus.rd_en) begin
        bus.rd_data_1 <= rv_1;
        bus.rd_data_2 <= rv_2;
      end
    end
  end
endmodule

// File: tb/tb_carrd_vrf.sv
// tb_carrd_vrf: directed self-checking bench for carrd_vrf
module tb_carrd_vrf;
  logic clk = 1'b0;
  logic nrst;
  int checks = 0;
  int errors = 0;
  carrd_vrf_if bus ();
  carrd_vrf dut (.clk(clk), .nrst(nrst), .bus(bus));
  always #5 clk = ~clk;
  logic [127:0] l1, l2, l3, l4;
  logic [511:0] exp_v3, exp_v7, pat_a, pat_5, pat_0, exp_v6;
  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic full_wr(input logic [4:0] a, input logic [511:0] v);
    bus.v_reg_wr_en = 1'b1;
    bus.reg_wr_addr = a;
    {bus.reg_wr_data_4, bus.reg_wr_data_3, bus.reg_wr_data_2, bus.reg_wr_data} = v;
  endtask
  task automatic idle();
    bus.v_reg_wr_en = 1'b0;
    bus.el_wr_en    = 1'b0;
    bus.rd_en       = 1'b0;
    bus.sb_set      = 1'b0;
  endtask
  initial begin
    l1 = {32{4'h1}}; l2 = {32{4'h2}}; l3 = {32{4'h3}}; l4 = {32{4'h4}};
    exp_v3 = {l4, l3, l2, l1};
    pat_a  = {128{4'hA}};
    pat_5  = {128{4'h5}};
    pat_0  = '0;
    exp_v7 = {pat_a[511:32], 32'hDEADBEEF};
    exp_v6 = {128{4'h6}};
    idle();
    bus.reg_wr_addr = '0; bus.reg_wr_data = '0; bus.reg_wr_data_2 = '0;
    bus.reg_wr_data_3 = '0; bus.reg_wr_data_4 = '0;
    bus.rd_addr_1 = '0; bus.rd_addr_2 = '0; bus.sb_addr = '0;
    nrst = 1'b0;
    step(); step();
    nrst = 1'b1;
    chk("rst_valid", {511'b0, bus.rd_valid}, 512'd0);
    // reset-state read
    bus.rd_en = 1'b1; bus.rd_addr_1 = 5'd5; bus.rd_addr_2 = 5'd31;
    step(); idle();
    chk("rst_rd_valid", {511'b0, bus.rd_valid}, 512'd1);
    chk("rst_rd1", bus.rd_data_1, pat_0);
    chk("rst_rd2", bus.rd_data_2, pat_0);
    chk("rst_busy1", {511'b0, bus.busy_1}, 512'd0);
    chk("rst_busy2", {511'b0, bus.busy_2}, 512'd0);
    step();
    chk("valid_drop", {511'b0, bus.rd_valid}, 512'd0);
    // full write v3 then read on both ports
    full_wr(5'd3, exp_v3);
    step(); idle();
    bus.rd_en = 1'b1; bus.rd_addr_1 = 5'd3; bus.rd_addr_2 = 5'd3;
    chk("no_early_valid", {511'b0, bus.rd_valid}, 512'd0);
    step(); idle();
    chk("v3_rd1", bus.rd_data_1, exp_v3);
    chk("v3_rd2_same", bus.rd_data_2, exp_v3);
    chk("v3_valid", {511'b0, bus.rd_valid}, 512'd1);
    step();
    chk("hold_rd1", bus.rd_data_1, exp_v3);
    chk("hold_valid", {511'b0, bus.rd_valid}, 512'd0);
    // element write on top of preloaded v7; other lanes carry junk that must be ignored
    full_wr(5'd7, pat_a);
    step(); idle();
    bus.el_wr_en = 1'b1; bus.reg_wr_addr = 5'd7;
    bus.reg_wr_data = {96'hFFFF_0000_1234_5678_9ABC_DEF0, 32'hDEADBEEF};
    bus.reg_wr_data_2 = l2; bus.reg_wr_data_3 = l3; bus.reg_wr_data_4 = l4;
    step(); idle();
    bus.rd_en = 1'b1; bus.rd_addr_1 = 5'd7; bus.rd_addr_2 = 5'd3;
    step(); idle();
    chk("el_wr", bus.rd_data_1, exp_v7);
    chk("el_other", bus.rd_data_2, exp_v3);
    // both strobes: full write wins; v0 is writable
    full_wr(5'd6, exp_v6); bus.el_wr_en = 1'b1;
    step(); idle();
    full_wr(5'd0, pat_5);
    step(); idle();
    bus.rd_en = 1'b1; bus.rd_addr_1 = 5'd6; bus.rd_addr_2 = 5'd0;
    step(); idle();
    chk("both_strobes", bus.rd_data_1, exp_v6);
    chk("v0_writable", bus.rd_data_2, pat_5);
    // scoreboard set / clear / set-wins, no same-cycle forwarding
    bus.sb_set = 1'b1; bus.sb_addr = 5'd9; bus.rd_addr_1 = 5'd9; bus.rd_addr_2 = 5'd8;
    #1;
    chk("sb_no_fwd", {511'b0, bus.busy_1}, 512'd0);
    step(); idle();
    chk("sb_set", {511'b0, bus.busy_1}, 512'd1);
    chk("sb_other", {511'b0, bus.busy_2}, 512'd0);
    full_wr(5'd9, pat_5);
    #1;
    chk("sb_clr_no_fwd", {511'b0, bus.busy_1}, 512'd1);
    step(); idle();
    chk("sb_clr", {511'b0, bus.busy_1}, 512'd0);
    full_wr(5'd9, pat_a); bus.sb_set = 1'b1; bus.sb_addr = 5'd9;
    step(); idle();
    chk("sb_set_wins", {511'b0, bus.busy_1}, 512'd1);
    // full-write collision on v4 (old value 0)
    full_wr(5'd4, pat_5); bus.rd_en = 1'b1; bus.rd_addr_1 = 5'd4; bus.rd_addr_2 = 5'd3;
    step(); idle();
`ifdef CARRD_VRF_BYPASS_EN
    chk("coll_full", bus.rd_data_1, pat_5);
`else
    chk("coll_full", bus.rd_data_1, pat_0);
`endif
    chk("coll_other_port", bus.rd_data_2, exp_v3);
    bus.rd_en = 1'b1;
    step(); idle();
    chk("coll_follow", bus.rd_data_1, pat_5);
    // element-write collision on v7, port 2 only
    bus.el_wr_en = 1'b1; bus.reg_wr_addr = 5'd7; bus.reg_wr_data = {96'h0, 32'h0BADF00D};
    bus.rd_en = 1'b1; bus.rd_addr_1 = 5'd6; bus.rd_addr_2 = 5'd7;
    step(); idle();
`ifdef CARRD_VRF_BYPASS_EN
    chk("coll_el", bus.rd_data_2, {pat_a[511:32], 32'h0BADF00D});
`else
    chk("coll_el", bus.rd_data_2, exp_v7);
`endif
    chk("coll_el_p1", bus.rd_data_1, exp_v6);
    // back-to-back reads
    bus.rd_en = 1'b1; bus.rd_addr_1 = 5'd3;
    step();
    chk("b2b_1", bus.rd_data_1, exp_v3);
    bus.rd_addr_1 = 5'd7;
    step(); idle();
    chk("b2b_2", bus.rd_data_1, {pat_a[511:32], 32'h0BADF00D});
    chk("b2b_valid", {511'b0, bus.rd_valid}, 512'd1);
    // mid-operation reset with a concurrent read and a write that must be dropped
    full_wr(5'd2, pat_a);
    step(); idle();
    nrst = 1'b0; bus.rd_en = 1'b1; bus.rd_addr_1 = 5'd2;
    full_wr(5'd2, pat_5); bus.sb_set = 1'b1; bus.sb_addr = 5'd2;
    step(); idle();
    nrst = 1'b1; bus.rd_addr_2 = 5'd9;
    #1;
    chk("mid_rst_valid", {511'b0, bus.rd_valid}, 512'd0);
    chk("mid_rst_rd1", bus.rd_data_1, pat_0);
    chk("mid_rst_busy", {511'b0, bus.busy_1}, 512'd0);
    chk("mid_rst_busy9", {511'b0, bus.busy_2}, 512'd0);
    bus.rd_en = 1'b1; bus.rd_addr_2 = 5'd3;
    step(); idle();
    chk("post_rst_v2", bus.rd_data_1, pat_0);
    chk("post_rst_v3", bus.rd_data_2, pat_0);
    chk("post_rst_valid", {511'b0, bus.rd_valid}, 512'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/carrd_vrf.md
Name: carrd_vrf

Overview:
- Vector register file for the Carrd coprocessor; the receiving end of the writeback stage's register-write interface.
- Holds 32 vector registers of 512 bits, each stored as four 128-bit lane slices.
- Accepts full-register writes and element-0 writes from writeback.
- Serves two registered read ports to the operand-fetch stage.
- Keeps a busy scoreboard that the issue logic uses for RAW hazard checks.

Parameters:
NUM_REGS, 32, number of vector registers (addressable by 5-bit address)
LANE_W, 128, width of one lane slice; register width = 4*LANE_W
ELEM_W, 32, width of element-0 write

Ports:
clk  input  1  clock, all state updates on rising edge
nrst  input  1  synchronous active-low reset
v_reg_wr_en  input  1  full-register write strobe from writeback
el_wr_en  input  1  element-0 write strobe (reduction results)
reg_wr_addr  input  5  destination register for either write
reg_wr_data  input  128  lane 1 data -> bits [127:0]
reg_wr_data_2  input  128  lane 2 data -> bits [255:128]
reg_wr_data_3  input  128  lane 3 data -> bits [383:256]
reg_wr_data_4  input  128  lane 4 data -> bits [511:384]
rd_en  input  1  read request for both ports
rd_addr_1  input  5  read port 1 address
rd_addr_2  input  5  read port 2 address
rd_data_1  output  512  read port 1 data, registered
rd_data_2  output  512  read port 2 data, registered
rd_valid  output  1  one-cycle pulse: rd_data_* updated this cycle
sb_set  input  1  issue marks a destination as pending
sb_addr  input  5  register to mark pending
busy_1  output  1  scoreboard bit for rd_addr_1, combinational
busy_2  output  1  scoreboard bit for rd_addr_2, combinational

Behaviour:
- Clock is clk; reset is synchronous and active-low (nrst). Reset is sampled only on the rising edge of clk.
- Reset (nrst=0 at posedge):
  - All 32 registers cleared to 0.
  - Scoreboard cleared to all-zero.
  - rd_data_1 and rd_data_2 cleared to 0; rd_valid=0.
  - A read requested in the same cycle is discarded; no rd_valid follows.
  - Writes and sb_set presented during reset are ignored.
- Full write (v_reg_wr_en=1): reg[reg_wr_addr] <= {reg_wr_data_4, reg_wr_data_3, reg_wr_data_2, reg_wr_data}.
- Element write (el_wr_en=1, v_reg_wr_en=0): reg[reg_wr_addr][31:0] <= reg_wr_data[31:0]; bits [511:32] retained.
- Both strobes high: full write only; el_wr_en is ignored.
- Any accepted write clears sb[reg_wr_addr].
- v0 is an ordinary writable register (mask source). No hardwired zero.
- Read latency is 1 cycle:
  - rd_en=1 at edge N -> rd_data_1 = reg[rd_addr_1], rd_data_2 = reg[rd_addr_2], and rd_valid=1 after edge N.
  - rd_valid drops after edge N+1 unless rd_en is still 1.
  - Back-to-back reads give one result per cycle.
- rd_en=0: rd_data_* hold their last value; rd_valid=0.
- Same-address read on both ports returns identical data.
- Scoreboard:
  - sb_set=1 sets sb[sb_addr] at the edge.
  - Same edge: write clears and sb_set sets the same address -> set wins (a new producer has issued).
  - busy_1 = sb[rd_addr_1] and busy_2 = sb[rd_addr_2], read combinationally from current state. No forwarding of same-cycle set or clear.
- Read/write collision on the same address in one cycle: the returned value depends on CARRD_VRF_BYPASS_EN (below).

Optional Feature:
- Macro: CARRD_VRF_BYPASS_EN.
- Defined: a read that collides with a same-cycle write returns the post-write value.
  - Full write: returns the full new register.
  - Element write: returns {old[511:32], reg_wr_data[31:0]}.
  - Applies independently to each port.
- Undefined: the colliding read returns the pre-write value; the write still commits at the same edge.

Test Plan:
- Reset then read: nrst=0 for 2 cycles; rd_en=1, rd_addr_1=5, rd_addr_2=31 -> next cycle rd_valid=1, both rd_data=0, busy_1=busy_2=0.
- Full write v3 with lanes 0x11..1, 0x22..2, 0x33..3, 0x44..4; next cycle read rd_addr_1=3 -> rd_data_1 = {0x44..4, 0x33..3, 0x22..2, 0x11..1}, with one-cycle latency.
- Element write: v7 preloaded 0xAA..A; el_wr_en=1, reg_wr_data[31:0]=0xDEADBEEF -> read gives 0xAA..A in [511:32] and 0xDEADBEEF in [31:0].
- Scoreboard: sb_set addr 9 -> busy_1=1 for rd_addr_1=9. A write to 9 clears it next cycle. Simultaneous write to 9 plus sb_set 9 -> busy stays 1.
- Collision: write v4=0x55..5 while rd_en with rd_addr_1=4 (old 0x0).
  - With CARRD_VRF_BYPASS_EN: rd_data_1=0x55..5.
  - Without: rd_data_1=0x0; a follow-up read returns 0x55..5.
- Mid-operation reset: rd_en=1 and nrst=0 on the same edge with v2 previously written -> rd_valid=0, rd_data=0; a subsequent read of v2 returns 0.
